beta_normalize: RTL and testbench
=================================

Name: beta_normalize

Overview:
Multi-cycle normalizer for the BETA datapath. It is the inverse of the barrel shift: instead of shifting by a given amount, it finds the left-shift amount that normalizes an operand. It iteratively left-shifts the operand one bit per cycle until the MSB is significant, then returns the normalized word and the shift count. It sits beside the ALU shift unit, serves CLZ/CLS-style operations and soft-float normalization, and uses valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand/result width in bits
CW, 6, count width; must hold the value WIDTH

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept an operand
MODE  input  1  0 = unsigned (leading zeros), 1 = signed (redundant sign bits)
A  input  WIDTH  operand
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
Y  output  WIDTH  normalized operand
COUNT  output  CW  left-shift amount applied
ZERO  output  1  captured operand was all zeros

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: state IDLE, out_valid=0, Y=0, COUNT=0, ZERO=0. in_ready=1 after reset, since in_ready is combinational (state==IDLE).
- States: IDLE, RUN, DONE.
- IDLE:
  - On in_valid=1 at an edge, latch A into the shift register, latch MODE, COUNT<=0, ZERO<=(A==0), go to RUN.
  - in_valid=0: stay in IDLE.
- RUN: each edge evaluates the done condition on the current register.
  - Unsigned: done when reg[WIDTH-1]=1 or COUNT==WIDTH.
  - Signed: done when reg[WIDTH-1]!=reg[WIDTH-2] or COUNT==WIDTH-1.
  - Done: go to DONE; out_valid<=1.
  - Else: reg<=reg<<1 with zero fill; COUNT<=COUNT+1.
- Latency: a result with COUNT=n has out_valid high n+1 cycles after the accept edge.
  - Worst case unsigned zero: 33 cycles.
  - Worst case signed 0 or all-ones: 32 cycles.
- DONE:
  - Y, COUNT and ZERO stay stable while out_valid=1 and out_ready=0.
  - On out_ready=1 at an edge, out_valid<=0 and go to IDLE.
  - No same-cycle re-accept; the next operand is accepted at the earliest one cycle later.
- Y is driven from the shift register in every state. Y holds its last value in IDLE; consumers qualify Y with out_valid.
- Boundaries:
  - Unsigned A=0: COUNT=32, Y=0, ZERO=1.
  - Signed A=0: COUNT=31, Y=0, ZERO=1.
  - Signed A=all-ones: COUNT=31, Y=0x80000000, ZERO=0.
  - Operand already normalized: COUNT=0, Y=A.
- in_valid, A and MODE are ignored outside IDLE. out_ready is ignored outside DONE.
- Reset asserted in RUN or DONE: abort; out_valid stays or returns to 0 on that edge; no result is produced.
- COUNT never exceeds WIDTH, and the counter never wraps.

Test Plan:
1. Unsigned A=0x00010000 -> COUNT=15, Y=0x80000000, ZERO=0, out_valid 16 cycles after accept.
2. Unsigned A=0x80000000 -> COUNT=0, Y=0x80000000, out_valid 1 cycle after accept. Then unsigned A=0 -> COUNT=32, Y=0, ZERO=1, out_valid 33 cycles after accept.
3. Signed A=0xFFFFF000 -> COUNT=19, Y=0x80000000. Signed A=0x00000001 -> COUNT=30, Y=0x40000000. Signed A=0xFFFFFFFF -> COUNT=31, Y=0x80000000.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, Y and COUNT stable throughout. Raise out_ready -> out_valid=0 and in_ready=1 next cycle.
5. Drive in_valid=1 with a different A during RUN -> ignored; result matches the first operand; in_ready=0 throughout RUN/DONE.
6. Assert reset 3 cycles into RUN for A=0x00000100 -> out_valid never rises; state IDLE, COUNT=0, Y=0. A following unsigned A=0x00000100 -> COUNT=23, Y=0x80000000.

Source files
------------

// File: rtl/beta_normalize.sv
// Iterative normalizer: shifts the operand left one bit per cycle until its MSB is significant.
// Latency COUNT+1 cycles after accept; the result is held in DONE until out_ready is seen.
module beta_normalize #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             MODE,
    input  logic [WIDTH-1:0] A,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic [CW-1:0]    COUNT,
    output logic             ZERO
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] MAX_U = CW'(WIDTH);
    localparam logic [CW-1:0] MAX_S = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    count_q, count_d;
    logic             mode_q, mode_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic             done_c;

    // Signed operands stop one step early: the sign bit itself is never shifted out.
    always_comb begin
        done_c = 1'b0;
        if (mode_q) begin
            done_c = (sh_q[WIDTH-1] != sh_q[WIDTH-2]) || (count_q == MAX_S);
        end else begin
            done_c = sh_q[WIDTH-1] || (count_q == MAX_U);
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        count_d     = count_q;
        mode_d      = mode_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sh_d    = A;
                    mode_d  = MODE;
                    count_d = '0;
                    zero_d  = (A == '0);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (done_c) begin
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    sh_d    = {sh_q[WIDTH-2:0], 1'b0};
                    count_d = count_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sh_q        <= '0;
            count_q     <= '0;
            mode_q      <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign Y         = sh_q;
    assign COUNT     = count_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_beta_normalize.sv
// Directed bench for beta_normalize: vector table plus backpressure, ignore-while-busy and abort sequences.
module tb_beta_normalize;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        MODE;
    logic [31:0] A;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Y;
    logic [5:0]  COUNT;
    logic        ZERO;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    beta_normalize #(.WIDTH(32), .CW(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .MODE      (MODE),
        .A         (A),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .COUNT     (COUNT),
        .ZERO      (ZERO)
    );

    typedef struct {
        logic        mode;
        logic [31:0] a;
        logic [31:0] y;
        logic [5:0]  cnt;
        logic        zero;
    } vec_t;

    vec_t vecs[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Issue one operand and check the result; hold = cycles of out_ready=0 in DONE,
    // inject = keep in_valid high with a different operand while busy.
    task automatic run_op(input vec_t v, input int hold, input bit inject);
        int lat;
        bit busy_ok;
        logic [31:0] y0;
        logic [5:0]  c0;
        lat = 0;
        while (!in_ready && lat < 50) begin
            step();
            lat++;
        end
        chk("in_ready before issue", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        MODE     = v.mode;
        A        = v.a;
        step();
        if (inject) begin
            A    = ~v.a;
            MODE = ~v.mode;
        end else begin
            in_valid = 1'b0;
        end
        lat     = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            step();
            lat++;
        end
        chk("in_ready low while busy", {63'd0, busy_ok}, 64'd1);
        chk("latency", 64'(lat), 64'(v.cnt) + 64'd1);
        chk("Y", {32'd0, Y}, {32'd0, v.y});
        chk("COUNT", {58'd0, COUNT}, {58'd0, v.cnt});
        chk("ZERO", {63'd0, ZERO}, {63'd0, v.zero});
        if (hold > 0) begin
            y0 = Y;
            c0 = COUNT;
            busy_ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                step();
                if (!out_valid || Y !== y0 || COUNT !== c0 || in_ready) busy_ok = 1'b0;
            end
            chk("stable under backpressure", {63'd0, busy_ok}, 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_valid drops after handshake", {63'd0, out_valid}, 64'd0);
        chk("in_ready after handshake", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        bit never;
        vec_t v;
        vecs[0]  = '{1'b0, 32'h0001_0000, 32'h8000_0000, 6'd15, 1'b0};
        vecs[1]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 6'd0,  1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 6'd32, 1'b1};
        vecs[3]  = '{1'b1, 32'hFFFF_F000, 32'h8000_0000, 6'd19, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0001, 32'h4000_0000, 6'd30, 1'b0};
        vecs[5]  = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 6'd31, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 6'd31, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0100, 32'h8000_0000, 6'd23, 1'b0};
        vecs[8]  = '{1'b1, 32'h4000_0000, 32'h4000_0000, 6'd0,  1'b0};
        vecs[9]  = '{1'b0, 32'h1234_5678, 32'h91A2_B3C0, 6'd3,  1'b0};
        vecs[10] = '{1'b1, 32'h0000_FFFF, 32'h7FFF_8000, 6'd15, 1'b0};

        reset = 1'b1; in_valid = 1'b0; MODE = 1'b0; A = '0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        chk("reset in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset Y", {32'd0, Y}, 64'd0);
        chk("reset COUNT", {58'd0, COUNT}, 64'd0);
        chk("reset ZERO", {63'd0, ZERO}, 64'd0);

        for (int i = 0; i < 11; i++) run_op(vecs[i], 0, 1'b0);

        // Backpressure: result held for 5 cycles.
        run_op(vecs[3], 5, 1'b0);
        // Different operand offered while busy must be ignored.
        run_op(vecs[0], 2, 1'b1);

        // Abort with reset three cycles into RUN.
        in_valid = 1'b1; MODE = 1'b0; A = 32'h0000_0100;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        never = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) never = 1'b0;
            if (i == 0) begin
                chk("abort in_ready", {63'd0, in_ready}, 64'd1);
                chk("abort COUNT", {58'd0, COUNT}, 64'd0);
                chk("abort Y", {32'd0, Y}, 64'd0);
            end
            step();
        end
        chk("abort no result", {63'd0, never}, 64'd1);
        v = '{1'b0, 32'h0000_0100, 32'h8000_0000, 6'd23, 1'b0};
        run_op(v, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
